// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared types and constants for the M-extension issue controller.
package mdu_issue_ctrl_pkg;

  localparam int MDU_XLEN = 32;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_funct3_t;

  // Issue controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } mdu_ctrl_state_t;

  localparam logic [31:0] XLEN_MIN_SIGNED = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES        = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_issue_ctrl_special.sv
// Combinational detection of M-ops whose result is known without the mdu:
// divide by zero, signed divide overflow and multiply by zero.
module mdu_issue_ctrl_special
  import mdu_issue_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        is_special_o,
  output logic [31:0] special_result_o
);

  logic a_zero_s;
  logic b_zero_s;
  logic sovf_s;

  assign a_zero_s = (a_i == 32'h0000_0000);
  assign b_zero_s = (b_i == 32'h0000_0000);
  assign sovf_s   = (a_i == XLEN_MIN_SIGNED) && (b_i == ALL_ONES);

  // Classify the op and pick the architecturally defined result.
  always_comb begin
    is_special_o     = 1'b0;
    special_result_o = 32'h0000_0000;
    case (funct3_i)
      MUL, MULH, MULHSU, MULHU: begin
        if (a_zero_s || b_zero_s) begin
          is_special_o     = 1'b1;
          special_result_o = 32'h0000_0000;
        end else begin
          is_special_o     = 1'b0;
        end
      end
      DIV: begin
        if (b_zero_s) begin
          is_special_o     = 1'b1;
          special_result_o = ALL_ONES;
        end else if (sovf_s) begin
          is_special_o     = 1'b1;
          special_result_o = XLEN_MIN_SIGNED;
        end else begin
          is_special_o     = 1'b0;
        end
      end
      DIVU: begin
        if (b_zero_s) begin
          is_special_o     = 1'b1;
          special_result_o = ALL_ONES;
        end else begin
          is_special_o     = 1'b0;
        end
      end
      REM: begin
        if (b_zero_s) begin
          is_special_o     = 1'b1;
          special_result_o = a_i;
        end else if (sovf_s) begin
          is_special_o     = 1'b1;
          special_result_o = 32'h0000_0000;
        end else begin
          is_special_o     = 1'b0;
        end
      end
      REMU: begin
        if (b_zero_s) begin
          is_special_o     = 1'b1;
          special_result_o = a_i;
        end else begin
          is_special_o     = 1'b0;
        end
      end
      default: begin
        is_special_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/stall controller between EX and the mdu. Holds one M-op, keeps
// mdu_start high until done, resolves special cases locally, absorbs
// flushes of in-flight ops and flags a hung mdu via a watchdog.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int XLEN        = MDU_XLEN,
  parameter int WDOG_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mdu_start,
  output logic [2:0]      mdu_funct3,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  input  logic [XLEN-1:0] mdu_f,
  input  logic            mdu_done,
  output logic            err
);

  localparam int WDW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

  mdu_ctrl_state_t state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            stall_s;
  logic            is_special_s;
  logic [XLEN-1:0] special_result_s;
  logic            wdog_last_s;

  mdu_issue_ctrl_special u_special (
    .funct3_i         (ex_funct3),
    .a_i              (ex_rs1),
    .b_i              (ex_rs2),
    .is_special_o     (is_special_s),
    .special_result_o (special_result_s)
  );

  assign wdog_last_s = (wdog_q == WDOG_LAST);

  // Next-state, datapath capture and stall decode.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          stall_s  = 1'b1;
          funct3_d = ex_funct3;
          a_d      = ex_rs1;
          b_d      = ex_rs2;
          rd_d     = ex_rd;
          if (is_special_s) begin
            wb_data_d = special_result_s;
            wb_rd_d   = ex_rd;
            state_d   = RESP;
          end else begin
            wdog_d  = {WDW{1'b0}};
            state_d = RUN;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      RUN: begin
        stall_s = 1'b1;
        if (mdu_done) begin
          if (flush) begin
            // Flushed in the completing cycle: the result is discarded.
            state_d = IDLE;
          end else begin
            wb_data_d = mdu_f;
            wb_rd_d   = rd_q;
            state_d   = RESP;
          end
        end else if (wdog_last_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (flush) begin
          wdog_d  = {WDW{1'b0}};
          state_d = DRAIN;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      DRAIN: begin
        // The mdu cannot abort, so the killed op runs to completion silently.
        stall_s = ex_valid;
        if (mdu_done) begin
          state_d = IDLE;
        end else if (wdog_last_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      RESP: begin
        // The op is older than any flush seen here, so it always retires.
        stall_s = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall_s = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      funct3_q  <= 3'b000;
      a_q       <= {XLEN{1'b0}};
      b_q       <= {XLEN{1'b0}};
      rd_q      <= 5'd0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= {XLEN{1'b0}};
      wdog_q    <= {WDW{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
    end
  end

  assign stall      = stall_s;
  assign wb_valid   = (state_q == RESP);
  assign mdu_start  = (state_q == RUN) || (state_q == DRAIN);
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mdu_funct3 = funct3_q;
  assign mdu_a      = a_q;
  assign mdu_b      = b_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural fixed-latency mdu.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  localparam int MDU_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        stall, wb_valid, mdu_start, mdu_done, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mdu_a, mdu_b, mdu_f;
  logic [2:0]  mdu_funct3;
  logic        mdu_stuck;
  logic [7:0]  mdu_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.XLEN(32), .WDOG_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_start(mdu_start), .mdu_funct3(mdu_funct3), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_f(mdu_f), .mdu_done(mdu_done), .err(err)
  );

  function automatic logic [31:0] mdu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = 32'h0;
    case (f)
      3'd0: r = a * b;
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Behavioural mdu: done rises MDU_LAT cycles after start, held while start.
  always @(posedge clk) begin
    if (!rst || !mdu_start) mdu_cnt <= 8'd0;
    else if (!mdu_done)     mdu_cnt <= mdu_cnt + 8'd1;
  end
  assign mdu_done = mdu_start && !mdu_stuck && (mdu_cnt == 8'(MDU_LAT));
  assign mdu_f    = mdu_ref(mdu_funct3, mdu_a, mdu_b);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one op starting #1 after a posedge; returns #1 after a posedge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                        input int exp_lat, input bit exp_start, input int tail);
    int  wb_cnt;
    int  lat;
    bit  stall_bad;
    bit  start_seen;
    wb_cnt = 0; lat = -1; stall_bad = 1'b0; start_seen = 1'b0;
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) check_val({tag, "_start_at_accept"}, 32'(mdu_start), 32'd0);
      if (mdu_start) start_seen = 1'b1;
      if (wb_valid) begin
        wb_cnt++;
        lat = c;
        check_val({tag, "_data"}, wb_data, exp_data);
        check_val({tag, "_rd"}, 32'(wb_rd), 32'(rd));
        check_val({tag, "_resp_stall"}, 32'(stall), 32'd0);
        check_val({tag, "_resp_start"}, 32'(mdu_start), 32'd0);
        break;
      end else if (!stall) begin
        stall_bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_start_seen"}, 32'(start_seen), 32'(exp_start));
    check_val({tag, "_stall_gap"}, 32'(stall_bad), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int c = 0; c < tail; c++) begin
      @(negedge clk);
      if (wb_valid) wb_cnt++;
      @(posedge clk); #1;
    end
    check_val({tag, "_wb_count"}, 32'(wb_cnt), 32'd1);
  endtask

  initial begin
    int  wb_cnt;
    bit  stall_bad;
    rst = 1'b0; ex_valid = 1'b0; ex_funct3 = 3'd0; ex_rs1 = 32'h0; ex_rs2 = 32'h0;
    ex_rd = 5'd0; flush = 1'b0; mdu_stuck = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall",    32'(stall),      32'd0);
    check_val("rst_wb_valid", 32'(wb_valid),   32'd0);
    check_val("rst_start",    32'(mdu_start),  32'd0);
    check_val("rst_err",      32'(err),        32'd0);
    check_val("rst_wb_data",  wb_data,         32'd0);
    check_val("rst_wb_rd",    32'(wb_rd),      32'd0);
    check_val("rst_mdu_a",    mdu_a,           32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("mul_neg",   3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 5, 1'b1, 3);
    run_op("divu_zero", 3'b101, 32'd100,        32'd0,         5'd6,  32'hFFFF_FFFF, 1, 1'b0, 3);
    run_op("rem_ovf",   3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1, 1'b0, 3);
    run_op("div_ovf",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1, 1'b0, 3);
    run_op("remu_zero", 3'b111, 32'd17,         32'd0,         5'd9,  32'd17,        1, 1'b0, 3);
    run_op("mulh_zero", 3'b001, 32'd0,          32'd1234,      5'd10, 32'd0,         1, 1'b0, 3);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 5, 1'b1, 3);
    run_op("remu_a",    3'b111, 32'd17,         32'd5,         5'd12, 32'd2,         5, 1'b1, 0);
    run_op("remu_b",    3'b111, 32'd9,          32'd4,         5'd13, 32'd1,         5, 1'b1, 3);

    // DIV 20/3 flushed two cycles after accept; a new op waits in EX during DRAIN.
    ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd20; ex_rs2 = 32'd3; ex_rd = 5'd15;
    @(negedge clk);
    check_val("fl_accept_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("fl_run_start", 32'(mdu_start), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check_val("fl_flush_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; ex_funct3 = 3'b101; ex_rs1 = 32'd8; ex_rs2 = 32'd2; ex_rd = 5'd14;
    @(negedge clk);
    check_val("fl_drain_start", 32'(mdu_start), 32'd1);
    check_val("fl_drain_stall", 32'(stall),     32'd1);
    check_val("fl_drain_wb",    32'(wb_valid),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("fl_drain_start2", 32'(mdu_start), 32'd1);
    check_val("fl_drain_wb2",    32'(wb_valid),  32'd0);
    @(posedge clk); #1;
    run_op("divu_after", 3'b101, 32'd8, 32'd2, 5'd14, 32'd4, 5, 1'b1, 3);

    // Hung mdu: watchdog fires after 64 RUN cycles.
    mdu_stuck = 1'b1;
    ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd8; ex_rs2 = 32'd2; ex_rd = 5'd16;
    @(negedge clk);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    wb_cnt = 0; stall_bad = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (wb_valid) wb_cnt++;
      if (!stall) stall_bad = 1'b1;
      if (c == 64) begin
        check_val("wd_err_before", 32'(err),       32'd0);
        check_val("wd_start_before", 32'(mdu_start), 32'd1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("wd_err",       32'(err),       32'd1);
    check_val("wd_start_off", 32'(mdu_start), 32'd0);
    check_val("wd_idle_stall", 32'(stall),    32'd0);
    check_val("wd_run_stall", 32'(stall_bad), 32'd0);
    check_val("wd_no_wb",     32'(wb_cnt + int'(wb_valid)), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("wd_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;
    mdu_stuck = 1'b0;

    // Reset in the middle of RUN clears everything, including err.
    ex_valid = 1'b1; ex_funct3 = 3'b011; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'hFFFF_FFFF; ex_rd = 5'd17;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mrst_start",   32'(mdu_start),  32'd0);
    check_val("mrst_wb",      32'(wb_valid),   32'd0);
    check_val("mrst_err",     32'(err),        32'd0);
    check_val("mrst_stall",   32'(stall),      32'd0);
    check_val("mrst_wb_data", wb_data,         32'd0);
    check_val("mrst_wb_rd",   32'(wb_rd),      32'd0);
    check_val("mrst_funct3",  32'(mdu_funct3), 32'd0);
    check_val("mrst_mdu_a",   mdu_a,           32'd0);
    check_val("mrst_mdu_b",   mdu_b,           32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wb_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wb_valid || mdu_start) wb_cnt++;
    end
    check_val("mrst_quiet", 32'(wb_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
